// File: rtl/reduce_engine_pkg.sv
// Shared definitions for the reduce engine: FSM state encoding, default
// operand width, round counter width and a small population-count helper.
package reduce_engine_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int ROUND_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MIN,
    SUB,
    DONE
  } state_t;

  // Number of set flags among four; used to count nonzero operand registers.
  function automatic logic [2:0] count_ones4(input logic [3:0] flags);
    return {2'b00, flags[0]} + {2'b00, flags[1]} +
           {2'b00, flags[2]} + {2'b00, flags[3]};
  endfunction

endpackage

// File: rtl/reduce_engine_if.sv
// Bundle of the reduce engine's load / result handshake signals.
//   master : operand source and result consumer (drives in_valid, in_data, out_ready)
//   slave  : the engine (drives in_ready, a0..a3, out_valid, rounds, all_zero)
interface reduce_engine_if
  import reduce_engine_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   a2;
  logic [WIDTH-1:0]   a3;
  logic               out_valid;
  logic               out_ready;
  logic [ROUND_W-1:0] rounds;
  logic               all_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, a0, a1, a2, a3, out_valid, rounds, all_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, a0, a1, a2, a3, out_valid, rounds, all_zero
  );

endinterface

// File: rtl/reduce_engine_min_nonzero4.sv
// Combinational minimum over the nonzero members of four operands.
// Zero operands are excluded; if all four are zero the output is zero.
//   d0..d3 : operands
//   m      : smallest nonzero operand (or zero)
module min_nonzero4 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] m
);

  logic [WIDTH-1:0] d [4];
  logic             found;

  assign d[0] = d0;
  assign d[1] = d1;
  assign d[2] = d2;
  assign d[3] = d3;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    m     = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (d[i] != '0 && (!found || d[i] < m)) begin
        m     = d[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reduce_engine.sv
// Reduce engine: loads four operand words, then repeatedly subtracts the
// smallest nonzero operand from every nonzero operand until at most one
// nonzero operand remains. Each round is CHECK, MIN, SUB (3 cycles).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of reduce_engine_if
//           in_valid/in_data/in_ready : operand load handshake (IDLE only)
//           a0..a3                    : operand registers
//           out_valid/out_ready       : result handshake (DONE)
//           rounds                    : subtraction rounds for this result
//           all_zero                  : result is all zero (with out_valid)
module reduce_engine
  import reduce_engine_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  reduce_engine_if.slave bus
);

  state_t             state;
  logic [1:0]         cnt;
  logic [WIDTH-1:0]   regs [4];
  logic [WIDTH-1:0]   m;
  logic [ROUND_W-1:0] rounds;
  logic               out_valid;
  logic               all_zero;

  logic [3:0]         nz;
  logic [2:0]         nz_count;
  logic [WIDTH-1:0]   min_val;

  always_comb begin
    nz = '0;
    for (int i = 0; i < 4; i++) nz[i] = (regs[i] != '0);
  end

  assign nz_count = count_ones4(nz);

  min_nonzero4 #(.WIDTH(WIDTH)) u_min (
    .d0 (regs[0]),
    .d1 (regs[1]),
    .d2 (regs[2]),
    .d3 (regs[3]),
    .m  (min_val)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      m         <= '0;
      rounds    <= '0;
      out_valid <= 1'b0;
      all_zero  <= 1'b0;
      // NOTE: the four operand registers are ordinary flops feeding the
      // downstream decoder, so they are reset like any other state.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            regs[cnt] <= bus.in_data;
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              cnt    <= '0;
              rounds <= '0;
              state  <= CHECK;
            end
          end
        end

        CHECK: begin
          if (nz_count <= 3'd1) begin
            out_valid <= 1'b1;
            all_zero  <= (nz_count == 3'd0);
            state     <= DONE;
          end else begin
            state <= MIN;
          end
        end

        MIN: begin
          m     <= min_val;
          state <= SUB;
        end

        SUB: begin
          // m is the smallest nonzero value, so r - m never underflows and
          // every register equal to m drops to zero in this same round.
          for (int i = 0; i < 4; i++) begin
            if (nz[i]) regs[i] <= regs[i] - m;
          end
          if (rounds != '1) rounds <= rounds + 1'b1;
          state <= CHECK;
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            all_zero  <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.a0        = regs[0];
  assign bus.a1        = regs[1];
  assign bus.a2        = regs[2];
  assign bus.a3        = regs[3];
  assign bus.out_valid = out_valid;
  assign bus.rounds    = rounds;
  assign bus.all_zero  = all_zero;

endmodule

// File: doc/reduce_engine.md
REDUCE_ENGINE -- requirements
Module: reduce_engine

Interface
REQ-001 SHALL have parameter: WIDTH, 32, bit width of each operand and of outputs a0..a3.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  in_data holds a valid operand word.
REQ-005 SHALL have port: in_data  input  WIDTH  operand word; words arrive in order a0, a1, a2, a3.
REQ-006 SHALL have port: in_ready  output  1  block accepts an operand this cycle.
REQ-007 SHALL have ports: a0, a1, a2, a3  output  WIDTH each  operand registers, wired to the downstream index decoder.
REQ-008 SHALL have port: out_valid  output  1  a0..a3 hold a final result (at most one nonzero).
REQ-009 SHALL have port: out_ready  input  1  downstream consumed the result.
REQ-010 SHALL have port: rounds  output  3  number of subtraction rounds performed for the current result.
REQ-011 SHALL have port: all_zero  output  1  final result has all four registers zero; valid only while out_valid=1.

Function
REQ-012 SHALL implement FSM states IDLE, CHECK, MIN, SUB, DONE.
REQ-013 IDLE: in_ready=1; word accepted when in_valid=1; 2-bit word counter selects target register a[cnt], then cnt increments.
REQ-014 Acceptance of the 4th word (cnt=3) SHALL move IDLE->CHECK and clear cnt to 0 and rounds to 0.
REQ-015 CHECK: count nonzero registers; count<=1 -> DONE; otherwise -> MIN; lasts exactly 1 cycle.
REQ-016 MIN: register m = minimum over nonzero registers only (zero registers are ignored); -> SUB; 1 cycle.
REQ-017 SUB: every nonzero register r SHALL be replaced by r - m; zero registers unchanged; rounds increments (saturating at 7); -> CHECK.
REQ-018 Each round SHALL cost exactly 3 cycles (CHECK, MIN, SUB); ties at the minimum all become zero in the same SUB.
REQ-019 Nonzero count SHALL strictly decrease each round; at most 3 rounds; no underflow is possible because r >= m.
REQ-020 DONE: out_valid=1; all_zero=1 iff all four registers are zero; a0..a3 and rounds held stable.
REQ-021 DONE with out_ready=1 SHALL move to IDLE on that edge; a0..a3 retain values until overwritten by new loads.
REQ-022 in_ready SHALL be 0 in all states other than IDLE; in_valid outside IDLE is ignored.
REQ-023 Loads containing fewer than two nonzero words SHALL reach DONE after a single CHECK cycle with rounds=0.
REQ-024 Latency from 4th-word acceptance to out_valid SHALL be 1 + 3*rounds + 1 cycles.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, cnt=0, m=0, rounds=0, a0..a3=0, out_valid=0, all_zero=0, in_ready=1 (in_ready is decoded from IDLE).
REQ-026 Reset asserted mid-load or mid-round SHALL abandon the operation; partial words are discarded.

Structure
REQ-027 Shared package SHALL hold the state enum, the WIDTH default, and the round counter width (3).
REQ-028 Combinational minimum-of-nonzero finder SHALL be a separate sub-module, min_nonzero4 (four WIDTH inputs, WIDTH output, zeros excluded).
REQ-029 The engine SHALL contain no combinational path from in_data or out_ready to a0..a3.

Verification
REQ-030 Load 5,3,8,3 -> after round 1: 2,0,5,0; after round 2: 0,0,3,0; out_valid with rounds=2, all_zero=0, out_valid 8 cycles after 4th word.
REQ-031 Load 0,0,7,0 -> DONE after CHECK only, rounds=0, a2=7, out_valid 2 cycles after 4th word.
REQ-032 Load 4,4,4,4 -> single round zeroes all; rounds=1, all_zero=1.
REQ-033 Load 1,2,3,4 -> 0,1,2,3 -> 0,0,1,2 -> 0,0,0,1; rounds=3, a3=1; hold out_ready=0 for 5 cycles, outputs stable.
REQ-034 Deassert rst_n during MIN of a 2-round job -> all outputs zero, state IDLE, in_ready=1; new load 0,9,0,9 completes with all_zero=1, rounds=1.
REQ-035 in_valid gaps between words and in_valid asserted during SUB/DONE -> no extra word captured, result unchanged.
